// File: rtl/gbt_rx_frame_checker.sv
// GBT receive frame checker: finds sync/CRC-8 frame alignment, tracks the
// sequence number and delivers the validated 56-bit payload downstream.
module gbt_rx_frame_checker #(
    parameter logic [7:0]  SYNC_BYTE = 8'hBC,
    parameter int unsigned LOCK_CNT  = 4,
    parameter int unsigned LOSS_CNT  = 8
) (
    input  logic        clk_ik,
    input  logic        rst_ir,
    input  logic [79:0] gbt_data_i,
    input  logic        gbt_valid_i,
    input  logic        clear_counters_i,
    output logic [55:0] payload_o,
    output logic [7:0]  payload_seq_o,
    output logic        payload_valid_o,
    output logic        link_locked_o,
    output logic [15:0] crc_err_cnt_o,
    output logic [15:0] seq_err_cnt_o
);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [7:0] LOSS_N = 8'(LOSS_CNT);

    state_t      state;
    logic [79:0] s1_data;
    logic        s1_valid;
    logic        gap_q;
    logic [3:0]  good_cnt;
    logic [7:0]  bad_cnt;
    logic [7:0]  exp_seq;

    logic [7:0]  crc_calc;
    logic [7:0]  frame_seq;
    logic [7:0]  seq_next;
    logic [7:0]  bad_next;
    logic [3:0]  good_next;
    logic        frame_good;
    logic        seq_match;
    logic        force_hunt;
    logic        crc_inc;
    logic        seq_inc;

    // Bit-serial CRC-8, poly 0x07, init 0, MSB first, no reflection.
    function automatic logic [7:0] crc8(input logic [71:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 71; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    always_comb begin
        crc_calc   = crc8(s1_data[79:8]);
        frame_seq  = s1_data[71:64];
        frame_good = (s1_data[79:72] == SYNC_BYTE) &&
                     (crc_calc == s1_data[7:0]);
        seq_match  = (frame_seq == exp_seq);
        seq_next   = frame_seq + 8'd1;
        good_next  = good_cnt + 4'd1;
        bad_next   = bad_cnt + 8'd1;
        force_hunt = !s1_valid && gap_q;
        crc_inc    = s1_valid && (state == LOCKED) && !frame_good;
        seq_inc    = s1_valid && (state == LOCKED) &&
                     frame_good && !seq_match;
    end

    always_ff @(posedge clk_ik or posedge rst_ir) begin
        if (rst_ir) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_data  <= gbt_data_i;
            s1_valid <= gbt_valid_i;
        end
    end

    always_ff @(posedge clk_ik or posedge rst_ir) begin
        if (rst_ir) begin
            crc_err_cnt_o <= '0;
        end else if (clear_counters_i) begin
            crc_err_cnt_o <= '0;
        end else if (crc_inc && (crc_err_cnt_o != 16'hFFFF)) begin
            crc_err_cnt_o <= crc_err_cnt_o + 16'd1;
        end
    end

    always_ff @(posedge clk_ik or posedge rst_ir) begin
        if (rst_ir) begin
            seq_err_cnt_o <= '0;
        end else if (clear_counters_i) begin
            seq_err_cnt_o <= '0;
        end else if (seq_inc && (seq_err_cnt_o != 16'hFFFF)) begin
            seq_err_cnt_o <= seq_err_cnt_o + 16'd1;
        end
    end

    // gap_q remembers a missing word last cycle; two in a row force HUNT.
    always_ff @(posedge clk_ik or posedge rst_ir) begin
        if (rst_ir) begin
            state           <= HUNT;
            gap_q           <= 1'b0;
            good_cnt        <= '0;
            bad_cnt         <= '0;
            exp_seq         <= '0;
            payload_o       <= '0;
            payload_seq_o   <= '0;
            payload_valid_o <= 1'b0;
            link_locked_o   <= 1'b0;
        end else begin
            payload_valid_o <= 1'b0;
            gap_q           <= !s1_valid;
            if (force_hunt) begin
                state         <= HUNT;
                link_locked_o <= 1'b0;
                good_cnt      <= '0;
                bad_cnt       <= '0;
            end else if (s1_valid) begin
                unique case (state)
                    HUNT: begin
                        if (frame_good) begin
                            exp_seq  <= seq_next;
                            good_cnt <= 4'd1;
                            bad_cnt  <= '0;
                            if (LOCK_N == 4'd1) begin
                                state         <= LOCKED;
                                link_locked_o <= 1'b1;
                            end else begin
                                state <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (!frame_good) begin
                            state    <= HUNT;
                            good_cnt <= '0;
                        end else if (seq_match) begin
                            exp_seq  <= seq_next;
                            good_cnt <= good_next;
                            if (good_next == LOCK_N) begin
                                state         <= LOCKED;
                                link_locked_o <= 1'b1;
                                bad_cnt       <= '0;
                            end
                        end else begin
                            exp_seq  <= seq_next;
                            good_cnt <= 4'd1;
                        end
                    end
                    LOCKED: begin
                        if (frame_good) begin
                            bad_cnt         <= '0;
                            exp_seq         <= seq_next;
                            payload_o       <= s1_data[63:8];
                            payload_seq_o   <= frame_seq;
                            payload_valid_o <= 1'b1;
                        end else if (bad_next == LOSS_N) begin
                            state         <= HUNT;
                            link_locked_o <= 1'b0;
                            good_cnt      <= '0;
                            bad_cnt       <= '0;
                        end else begin
                            bad_cnt <= bad_next;
                        end
                    end
                    default: begin
                        state         <= HUNT;
                        link_locked_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gbt_rx_frame_checker.sv
// Directed bench for gbt_rx_frame_checker: vector table plus hand sequences
// for reset, counter saturation and clear priority.
module tb_gbt_rx_frame_checker;

    localparam logic [1:0] G = 2'd0;
    localparam logic [1:0] C = 2'd1;
    localparam logic [1:0] S = 2'd2;

    typedef struct {
        logic        v;
        logic [7:0]  seq;
        logic [1:0]  kind;
        logic        clr;
        logic        pv;
        logic        lk;
        logic [15:0] crc;
        logic [15:0] serr;
    } vec_t;

    logic        clk_ik = 1'b0;
    logic        rst_ir;
    logic [79:0] gbt_data_i;
    logic        gbt_valid_i;
    logic        clear_counters_i;
    logic [55:0] payload_o;
    logic [7:0]  payload_seq_o;
    logic        payload_valid_o;
    logic        link_locked_o;
    logic [15:0] crc_err_cnt_o;
    logic [15:0] seq_err_cnt_o;

    logic [79:0] s_data;
    logic        s_valid;
    logic        s_clear;
    logic [55:0] s_payload;
    logic [7:0]  s_pseq;
    logic        s_pv;
    logic        s_lk;
    logic [15:0] s_crc;
    logic [15:0] s_serr;

    vec_t        tbl[$];
    int          checks = 0;
    int          errors = 0;

    always #10 clk_ik = ~clk_ik;

    gbt_rx_frame_checker dut (
        .clk_ik           (clk_ik),
        .rst_ir           (rst_ir),
        .gbt_data_i       (gbt_data_i),
        .gbt_valid_i      (gbt_valid_i),
        .clear_counters_i (clear_counters_i),
        .payload_o        (payload_o),
        .payload_seq_o    (payload_seq_o),
        .payload_valid_o  (payload_valid_o),
        .link_locked_o    (link_locked_o),
        .crc_err_cnt_o    (crc_err_cnt_o),
        .seq_err_cnt_o    (seq_err_cnt_o)
    );

    gbt_rx_frame_checker #(
        .LOCK_CNT (1),
        .LOSS_CNT (255)
    ) dut_sat (
        .clk_ik           (clk_ik),
        .rst_ir           (rst_ir),
        .gbt_data_i       (s_data),
        .gbt_valid_i      (s_valid),
        .clear_counters_i (s_clear),
        .payload_o        (s_payload),
        .payload_seq_o    (s_pseq),
        .payload_valid_o  (s_pv),
        .link_locked_o    (s_lk),
        .crc_err_cnt_o    (s_crc),
        .seq_err_cnt_o    (s_serr)
    );

    // Byte-at-a-time reference CRC-8 (poly 0x07, init 0).
    function automatic logic [7:0] crc_ref(input logic [71:0] m);
        logic [7:0] c;
        c = 8'h00;
        for (int b = 8; b >= 0; b--) begin
            c = c ^ m[b*8 +: 8];
            for (int k = 0; k < 8; k++)
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [55:0] pl_of(input logic [7:0] seq);
        return {7{seq ^ 8'h5A}};
    endfunction

    function automatic logic [79:0] mk(input logic [7:0] seq,
                                       input logic [1:0] kind);
        logic [71:0] hdr;
        logic [7:0]  crc;
        hdr = {(kind == S) ? 8'hBD : 8'hBC, seq, pl_of(seq)};
        crc = crc_ref(hdr);
        if (kind == C)
            crc = crc ^ 8'h01;
        return {hdr, crc};
    endfunction

    task automatic add(input logic v, input logic [7:0] seq,
                       input logic [1:0] kind, input logic clr,
                       input logic pv, input logic lk,
                       input logic [15:0] crc, input logic [15:0] serr);
        vec_t r;
        r.v = v; r.seq = seq; r.kind = kind; r.clr = clr;
        r.pv = pv; r.lk = lk; r.crc = crc; r.serr = serr;
        tbl.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_ik);
        #1;
    endtask

    logic [7:0]  s_seq;
    logic [7:0]  s_last;
    int          run;
    int          total;
    int          first_pv;
    logic [7:0]  last_seq;
    logic [55:0] last_pl;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ir           = 1'b1;
        gbt_data_i       = '0;
        gbt_valid_i      = 1'b0;
        clear_counters_i = 1'b0;
        s_data           = '0;
        s_valid          = 1'b0;
        s_clear          = 1'b0;

        add(1, 8'h10, G, 0, 0, 0, 0, 0);
        add(1, 8'h11, G, 0, 0, 0, 0, 0);
        add(1, 8'h12, G, 0, 0, 0, 0, 0);
        add(1, 8'h13, G, 0, 0, 1, 0, 0);
        add(1, 8'h14, G, 0, 1, 1, 0, 0);
        add(1, 8'h15, G, 0, 1, 1, 0, 0);
        add(1, 8'h16, C, 0, 0, 1, 1, 0);
        add(1, 8'h16, G, 0, 1, 1, 1, 0);
        add(1, 8'h25, G, 0, 1, 1, 1, 1);
        add(1, 8'h26, G, 0, 1, 1, 1, 1);
        add(1, 8'hFE, G, 0, 1, 1, 1, 2);
        add(1, 8'hFF, G, 0, 1, 1, 1, 2);
        add(1, 8'h00, G, 0, 1, 1, 1, 2);
        add(1, 8'h01, G, 0, 1, 1, 1, 2);
        for (int k = 0; k < 8; k++)
            add(1, 8'h02, C, 0, 0, k < 7, 16'(2 + k), 2);
        add(1, 8'h30, G, 0, 0, 0, 9, 2);
        add(1, 8'h31, G, 0, 0, 0, 9, 2);
        add(1, 8'h32, G, 0, 0, 0, 9, 2);
        add(1, 8'h33, G, 0, 0, 1, 9, 2);
        add(0, 8'h00, G, 0, 0, 1, 9, 2);
        add(1, 8'h34, G, 0, 1, 1, 9, 2);
        add(0, 8'h00, G, 0, 0, 1, 9, 2);
        add(0, 8'h00, G, 0, 0, 0, 9, 2);
        add(1, 8'h40, G, 0, 0, 0, 9, 2);
        add(1, 8'h41, G, 0, 0, 0, 9, 2);
        add(1, 8'h42, S, 0, 0, 0, 9, 2);
        add(1, 8'h42, G, 0, 0, 0, 9, 2);
        add(1, 8'h43, G, 0, 0, 0, 9, 2);
        add(1, 8'h44, G, 0, 0, 0, 9, 2);
        add(1, 8'h45, G, 0, 0, 1, 9, 2);
        add(1, 8'h46, G, 1, 1, 1, 0, 0);
        add(1, 8'h47, C, 1, 0, 1, 0, 0);
        add(1, 8'h47, C, 0, 0, 1, 1, 0);

        step();
        step();
        chk("rst_payload", 64'(payload_o), 64'h0);
        chk("rst_pseq", 64'(payload_seq_o), 64'h0);
        chk("rst_pv", 64'(payload_valid_o), 64'h0);
        chk("rst_lock", 64'(link_locked_o), 64'h0);
        chk("rst_crc", 64'(crc_err_cnt_o), 64'h0);
        chk("rst_serr", 64'(seq_err_cnt_o), 64'h0);
        chk("rst_sat_lock", 64'(s_lk), 64'h0);
        rst_ir = 1'b0;

        last_seq = 8'h00;
        last_pl  = '0;
        for (int i = 0; i <= tbl.size(); i++) begin
            if (i < tbl.size()) begin
                gbt_valid_i = tbl[i].v;
                gbt_data_i  = mk(tbl[i].seq, tbl[i].kind);
            end else begin
                gbt_valid_i = 1'b0;
                gbt_data_i  = '0;
            end
            clear_counters_i = (i >= 1) ? tbl[i-1].clr : 1'b0;
            step();
            if (i >= 1) begin
                if (tbl[i-1].pv) begin
                    last_seq = tbl[i-1].seq;
                    last_pl  = pl_of(tbl[i-1].seq);
                end
                chk($sformatf("r%0d_pv", i-1),
                    64'(payload_valid_o), 64'(tbl[i-1].pv));
                chk($sformatf("r%0d_lock", i-1),
                    64'(link_locked_o), 64'(tbl[i-1].lk));
                chk($sformatf("r%0d_crc", i-1),
                    64'(crc_err_cnt_o), 64'(tbl[i-1].crc));
                chk($sformatf("r%0d_serr", i-1),
                    64'(seq_err_cnt_o), 64'(tbl[i-1].serr));
                chk($sformatf("r%0d_pseq", i-1),
                    64'(payload_seq_o), 64'(last_seq));
                chk($sformatf("r%0d_payload", i-1),
                    64'(payload_o), 64'(last_pl));
            end
        end
        clear_counters_i = 1'b0;

        // Asynchronous reset in the middle of a clock period.
        gbt_valid_i = 1'b1;
        gbt_data_i  = mk(8'h60, G);
        #4;
        rst_ir = 1'b1;
        #1;
        chk("amid_payload", 64'(payload_o), 64'h0);
        chk("amid_pseq", 64'(payload_seq_o), 64'h0);
        chk("amid_pv", 64'(payload_valid_o), 64'h0);
        chk("amid_lock", 64'(link_locked_o), 64'h0);
        chk("amid_crc", 64'(crc_err_cnt_o), 64'h0);
        chk("amid_serr", 64'(seq_err_cnt_o), 64'h0);
        step();
        rst_ir = 1'b0;

        first_pv = -1;
        for (int j = 0; j < 10; j++) begin
            gbt_valid_i = 1'b1;
            gbt_data_i  = mk(8'(8'h70 + j), G);
            step();
            if (payload_valid_o && first_pv < 0)
                first_pv = j;
        end
        chk("first_pv_after_rst", 64'(first_pv), 64'd5);
        gbt_valid_i = 1'b0;

        // Saturation and clear priority with LOCK_CNT=1, LOSS_CNT=255.
        s_valid = 1'b1;
        s_seq   = 8'h00;
        s_data  = mk(s_seq, G);
        s_seq   = s_seq + 8'd1;
        step();
        s_data = mk(s_seq, C);
        step();
        chk("sat_lock1", 64'(s_lk), 64'h1);
        chk("sat_lock_nopv", 64'(s_pv), 64'h0);
        run   = 1;
        total = 1;
        while (total < 65535) begin
            if (run == 254) begin
                s_data = mk(s_seq, G);
                s_seq  = s_seq + 8'd1;
                run    = 0;
            end else begin
                s_data = mk(s_seq, C);
                run++;
                total++;
            end
            step();
        end
        s_last = s_seq;
        s_data = mk(s_seq, G);
        s_seq  = s_seq + 8'd1;
        step();
        chk("sat_ffff", 64'(s_crc), 64'hFFFF);
        s_data = mk(s_seq, C);
        step();
        step();
        chk("sat_hold", 64'(s_crc), 64'hFFFF);
        chk("sat_lock_held", 64'(s_lk), 64'h1);
        chk("sat_serr", 64'(s_serr), 64'h0);
        chk("sat_pseq", 64'(s_pseq), 64'(s_last));
        chk("sat_payload", 64'(s_payload), 64'(pl_of(s_last)));
        s_clear = 1'b1;
        s_data  = mk(s_seq, G);
        step();
        chk("sat_clear_prio", 64'(s_crc), 64'h0);
        s_clear = 1'b0;
        s_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
